// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: ethertypes, frame limits, framer state encoding
// and the header byte selector.
package eth_pkg;

  localparam logic [15:0] ARP_PRTC = 16'h0806;
  localparam logic [15:0] IP_PRTC  = 16'h0800;

  localparam int unsigned MIN_FRAME_LEN = 60;
  localparam int unsigned MAX_FRAME_LEN = 1514;
  localparam int unsigned HDR_LEN       = 14;
  localparam int unsigned CNT_W         = 11;
  localparam int unsigned GAP_W         = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_PAD,
    ST_DROP,
    ST_GAP
  } tx_state_t;

  // Byte idx (0..13) of the header {dst, src, ethertype}, MSB first.
  function automatic logic [7:0] hdr_byte(input logic [47:0] dst, input logic [47:0] src,
                                          input logic [15:0] etype, input logic [3:0] idx);
    logic [111:0] hdr;
    logic [3:0]   rev;
    hdr = {dst, src, etype};
    rev = 4'd13 - idx;
    return hdr[{rev, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/eth_tx_arb.sv
// Fixed-priority two-requester arbiter (hi wins); grant holds until the frame
// completes and the lock is released.
module eth_tx_arb (
  input  logic clk,
  input  logic reset,
  input  logic req_hi,
  input  logic req_lo,
  input  logic arb_en,
  input  logic release_lock,
  output logic grant_lo
);

  logic locked;

  always_ff @(posedge clk) begin
    if (reset || release_lock) begin
      locked   <= 1'b0;
      grant_lo <= 1'b0;
    end else if (arb_en && !locked && (req_hi || req_lo)) begin
      locked   <= 1'b1;
      grant_lo <= !req_hi;
    end
  end

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: muxes ARP/IP payload streams behind a 14-byte header, enforces
// max length and inter-frame gap. Define ETH_TX_PAD_EN to zero-pad short frames to 60.
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned DEBUG      = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [47:0] local_mac_addr_in,
  input  logic [47:0] arp_dst_mac_in,
  input  logic [47:0] ip_dst_mac_in,
  input  logic [7:0]  arp_axis_tdata_in,
  input  logic        arp_axis_tvalid_in,
  input  logic        arp_axis_tlast_in,
  output logic        arp_axis_tready_o,
  input  logic [7:0]  ip_axis_tdata_in,
  input  logic        ip_axis_tvalid_in,
  input  logic        ip_axis_tlast_in,
  output logic        ip_axis_tready_o,
  output logic [7:0]  axis_tdata_out,
  output logic        axis_tvalid_out,
  output logic        axis_tlast_out,
  input  logic        axis_tready_in
);

  tx_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic [47:0]      dst_mac, src_mac;
  logic             sel_ip, arb_en, latch, done, s_tready;
  logic [7:0]       s_tdata;
  logic             s_tvalid, s_tlast, at_max, pad_short;
  logic [15:0]      etype;

  if (DEBUG != 0) begin : g_debug_hook
  end

  eth_tx_arb u_arb (
    .clk          (clk),
    .reset        (reset),
    .req_hi       (arp_axis_tvalid_in),
    .req_lo       (ip_axis_tvalid_in),
    .arb_en       (arb_en),
    .release_lock (done),
    .grant_lo     (sel_ip)
  );

  assign s_tdata  = sel_ip ? ip_axis_tdata_in  : arp_axis_tdata_in;
  assign s_tvalid = sel_ip ? ip_axis_tvalid_in : arp_axis_tvalid_in;
  assign s_tlast  = sel_ip ? ip_axis_tlast_in  : arp_axis_tlast_in;
  assign etype    = sel_ip ? IP_PRTC : ARP_PRTC;
  assign at_max   = (cnt == CNT_W'(MAX_FRAME_LEN - 1));

  assign arp_axis_tready_o = s_tready & ~sel_ip;
  assign ip_axis_tready_o  = s_tready & sel_ip;

`ifdef ETH_TX_PAD_EN
  assign pad_short = (cnt < CNT_W'(MIN_FRAME_LEN - 1));
`else
  assign pad_short = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      gap_cnt <= '0;
      dst_mac <= '0;
      src_mac <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      gap_cnt <= gap_nxt;
      if (latch) begin
        dst_mac <= arp_axis_tvalid_in ? arp_dst_mac_in : ip_dst_mac_in;
        src_mac <= local_mac_addr_in;
      end
    end
  end

  // Next state, counters and the combinational stream outputs.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    gap_nxt         = gap_cnt;
    axis_tdata_out  = 8'h00;
    axis_tvalid_out = 1'b0;
    axis_tlast_out  = 1'b0;
    s_tready        = 1'b0;
    arb_en          = 1'b0;
    latch           = 1'b0;
    done            = 1'b0;
    case (state)
      ST_IDLE: begin
        arb_en = 1'b1;
        if (arp_axis_tvalid_in || ip_axis_tvalid_in) begin
          latch     = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_HDR;
        end
      end
      ST_HDR: begin
        axis_tdata_out  = hdr_byte(dst_mac, src_mac, etype, cnt[3:0]);
        axis_tvalid_out = 1'b1;
        if (axis_tready_in) begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_W'(HDR_LEN - 1)) state_nxt = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        axis_tdata_out  = s_tdata;
        axis_tvalid_out = s_tvalid;
        axis_tlast_out  = s_tvalid && ((s_tlast && !pad_short) || at_max);
        s_tready        = axis_tready_in;
        if (s_tvalid && axis_tready_in) begin
          cnt_nxt = cnt + CNT_W'(1);
          if (s_tlast) begin
`ifdef ETH_TX_PAD_EN
            if (pad_short) state_nxt = ST_PAD;
            else
`endif
            done = 1'b1;
          end else if (at_max) begin
            state_nxt = ST_DROP;
          end
        end
      end
`ifdef ETH_TX_PAD_EN
      ST_PAD: begin
        axis_tvalid_out = 1'b1;
        axis_tlast_out  = (cnt == CNT_W'(MIN_FRAME_LEN - 1));
        if (axis_tready_in) begin
          if (axis_tlast_out) done = 1'b1;
          else cnt_nxt = cnt + CNT_W'(1);
        end
      end
`endif
      ST_DROP: begin
        s_tready = 1'b1;
        if (s_tvalid && s_tlast) done = 1'b1;
      end
      ST_GAP: begin
        gap_nxt = gap_cnt + GAP_W'(1);
        if (gap_cnt == GAP_W'(IFG_CYCLES - 1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Frame finished: release the grant and start the gap (or skip it when zero).
    if (done) begin
      cnt_nxt   = '0;
      gap_nxt   = '0;
      state_nxt = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed self-checking bench for eth_tx_framer; expectations follow ETH_TX_PAD_EN.
module tb_eth_tx_framer;

  localparam int unsigned IFG = 12;
`ifdef ETH_TX_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam logic [47:0] LOCAL_MAC = 48'h0200_0000_0001;
  localparam logic [47:0] ARP_DST   = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] IP_DST    = 48'h0A1B_2C3D_4E5F;

  logic        clk = 1'b0;
  logic        reset;
  logic [47:0] local_mac_addr_in, arp_dst_mac_in, ip_dst_mac_in;
  logic [7:0]  arp_axis_tdata_in, ip_axis_tdata_in, axis_tdata_out;
  logic        arp_axis_tvalid_in, arp_axis_tlast_in, arp_axis_tready_o;
  logic        ip_axis_tvalid_in, ip_axis_tlast_in, ip_axis_tready_o;
  logic        axis_tvalid_out, axis_tlast_out, axis_tready_in;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         cyc;
  } obeat_t;

  obeat_t     out_q[$];
  logic [7:0] arp_q[$];
  logic [7:0] ip_q[$];
  int         n_assert = 0;
  int         n_fail = 0;
  int         stab_err = 0;
  int         cyc = 0;
  int         tlast_seen = 0;
  bit         rdy_toggle = 1'b0;
  logic       arp_take = 1'b0, ip_take = 1'b0;
  logic       prev_stall = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = 8'h00;

  eth_tx_framer #(.IFG_CYCLES(IFG), .DEBUG(0)) dut (
    .clk                (clk),
    .reset              (reset),
    .local_mac_addr_in  (local_mac_addr_in),
    .arp_dst_mac_in     (arp_dst_mac_in),
    .ip_dst_mac_in      (ip_dst_mac_in),
    .arp_axis_tdata_in  (arp_axis_tdata_in),
    .arp_axis_tvalid_in (arp_axis_tvalid_in),
    .arp_axis_tlast_in  (arp_axis_tlast_in),
    .arp_axis_tready_o  (arp_axis_tready_o),
    .ip_axis_tdata_in   (ip_axis_tdata_in),
    .ip_axis_tvalid_in  (ip_axis_tvalid_in),
    .ip_axis_tlast_in   (ip_axis_tlast_in),
    .ip_axis_tready_o   (ip_axis_tready_o),
    .axis_tdata_out     (axis_tdata_out),
    .axis_tvalid_out    (axis_tvalid_out),
    .axis_tlast_out     (axis_tlast_out),
    .axis_tready_in     (axis_tready_in)
  );

  always #5 clk = ~clk;

  // Sample handshakes and output beats mid-cycle; flag any change during a stall.
  initial forever begin
    @(negedge clk);
    cyc++;
    arp_take = arp_axis_tvalid_in && arp_axis_tready_o;
    ip_take  = ip_axis_tvalid_in && ip_axis_tready_o;
    if (prev_stall && !reset &&
        (!axis_tvalid_out || axis_tdata_out !== prev_data || axis_tlast_out !== prev_last))
      stab_err++;
    prev_stall = axis_tvalid_out && !axis_tready_in && !reset;
    prev_data  = axis_tdata_out;
    prev_last  = axis_tlast_out;
    if (axis_tvalid_out && axis_tready_in) begin
      out_q.push_back('{axis_tdata_out, axis_tlast_out, cyc});
      if (axis_tlast_out) tlast_seen++;
    end
  end

  // Source streams and downstream ready, updated just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (arp_take && arp_q.size() != 0) arp_q.delete(0);
    if (ip_take && ip_q.size() != 0) ip_q.delete(0);
    arp_axis_tvalid_in = (arp_q.size() != 0);
    arp_axis_tdata_in  = (arp_q.size() != 0) ? arp_q[0] : 8'h00;
    arp_axis_tlast_in  = (arp_q.size() == 1);
    ip_axis_tvalid_in  = (ip_q.size() != 0);
    ip_axis_tdata_in   = (ip_q.size() != 0) ? ip_q[0] : 8'h00;
    ip_axis_tlast_in   = (ip_q.size() == 1);
    axis_tready_in     = rdy_toggle ? ~axis_tready_in : 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pay(input bit is_ip, input int i);
    return is_ip ? 8'(i + 7) : (8'hA0 ^ 8'(i * 3));
  endfunction

  function automatic int exp_len(input int plen);
    int n;
    n = (plen + 14 > 1514) ? 1514 : plen + 14;
    if (PAD && n < 60) n = 60;
    return n;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [47:0] dst, input logic [15:0] etype,
                                          input bit is_ip, input int plen, input int i);
    logic [111:0] h;
    h = {dst, LOCAL_MAC, etype};
    if (i < 14) return 8'(h >> (8 * (13 - i)));
    if (i - 14 < plen) return pay(is_ip, i - 14);
    return 8'h00;
  endfunction

  task automatic push(input bit is_ip, input int n);
    for (int i = 0; i < n; i++) begin
      if (is_ip) ip_q.push_back(pay(1'b1, i));
      else arp_q.push_back(pay(1'b0, i));
    end
  endtask

  task automatic clear_capture();
    out_q.delete();
    tlast_seen = 0;
    stab_err   = 0;
  endtask

  task automatic wait_frames(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (tlast_seen < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check({tag, " frame done"}, 32'(tlast_seen >= n), 32'd1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  // Checks one captured frame starting at index first; returns index after it.
  task automatic check_frame(input string tag, input int first, input logic [47:0] dst,
                             input logic [15:0] etype, input bit is_ip, input int plen,
                             output int next);
    int last_i, bad, n;
    n = exp_len(plen);
    last_i = -1;
    for (int i = first; i < out_q.size(); i++) begin
      if (out_q[i].last) begin
        last_i = i;
        break;
      end
    end
    check({tag, " length"}, 32'(last_i - first + 1), 32'(n));
    bad = 0;
    for (int i = 0; i < n && first + i < out_q.size(); i++)
      if (out_q[first + i].data !== exp_byte(dst, etype, is_ip, plen, i)) bad++;
    check({tag, " byte errors"}, 32'(bad), 32'd0);
    next = last_i + 1;
  endtask

  initial begin
    int nx, nx2, k;
    reset = 1'b1;
    local_mac_addr_in = LOCAL_MAC;
    arp_dst_mac_in = ARP_DST;
    ip_dst_mac_in = IP_DST;
    arp_axis_tdata_in = 8'h00; arp_axis_tvalid_in = 1'b0; arp_axis_tlast_in = 1'b0;
    ip_axis_tdata_in = 8'h00;  ip_axis_tvalid_in = 1'b0;  ip_axis_tlast_in = 1'b0;
    axis_tready_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset tvalid", 32'(axis_tvalid_out), 32'd0);
    check("reset tlast", 32'(axis_tlast_out), 32'd0);
    check("reset tdata", 32'(axis_tdata_out), 32'd0);
    check("reset treadys", 32'({arp_axis_tready_o, ip_axis_tready_o}), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;

    // ARP 28-byte payload; MAC inputs change mid-frame and must not leak in.
    clear_capture();
    push(1'b0, 28);
    repeat (6) @(posedge clk);
    #2;
    local_mac_addr_in = 48'h1234_5678_9ABC;
    arp_dst_mac_in = 48'h0000_1111_2222;
    wait_frames("arp28", 1, 400);
    check_frame("arp28", 0, ARP_DST, 16'h0806, 1'b0, 28, nx);
    check("arp28 tlast count", 32'(tlast_seen), 32'd1);
    local_mac_addr_in = LOCAL_MAC;
    arp_dst_mac_in = ARP_DST;

    // Simultaneous ARP and IP requests: ARP first, then IP after the gap.
    // Between frames: IFG_CYCLES gap cycles plus the one IDLE selection cycle.
    clear_capture();
    push(1'b0, 28);
    push(1'b1, 46);
    wait_frames("arb", 2, 800);
    check_frame("arb first arp", 0, ARP_DST, 16'h0806, 1'b0, 28, nx);
    check_frame("arb second ip", nx, IP_DST, 16'h0800, 1'b1, 46, nx2);
    if (nx > 0 && nx < out_q.size())
      check("arb idle gap", 32'(out_q[nx].cyc - out_q[nx - 1].cyc - 1), 32'(IFG + 1));
    else
      check("arb idle gap index", 32'(nx), 32'd0);

    // IP 100 bytes with downstream ready toggling every cycle.
    clear_capture();
    rdy_toggle = 1'b1;
    push(1'b1, 100);
    wait_frames("ip100", 1, 800);
    rdy_toggle = 1'b0;
    check_frame("ip100", 0, IP_DST, 16'h0800, 1'b1, 100, nx);
    check("ip100 stall stability", 32'(stab_err), 32'd0);
    check("ip100 tlast count", 32'(tlast_seen), 32'd1);

    // IP 1600 bytes: truncated at 1514 with tlast, remainder drained silently.
    clear_capture();
    push(1'b1, 1600);
    wait_frames("ip1600", 1, 4000);
    k = 0;
    while (ip_q.size() != 0 && k < 400) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(posedge clk);
    #2;
    check("ip1600 input drained", 32'(ip_q.size()), 32'd0);
    check_frame("ip1600", 0, IP_DST, 16'h0800, 1'b1, 1600, nx);
    check("ip1600 total out beats", 32'(out_q.size()), 32'd1514);
    check("ip1600 tlast count", 32'(tlast_seen), 32'd1);

    // Reset after 20 output bytes, then a clean frame.
    clear_capture();
    push(1'b1, 100);
    k = 0;
    while (out_q.size() < 20 && k < 200) begin
      @(posedge clk);
      k++;
    end
    #2;
    check("mid-frame reached byte 20", 32'(out_q.size() >= 20), 32'd1);
    reset = 1'b1;
    ip_q.delete();
    ip_axis_tvalid_in = 1'b0;
    ip_axis_tlast_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid reset tvalid", 32'(axis_tvalid_out), 32'd0);
    check("mid reset tlast", 32'(axis_tlast_out), 32'd0);
    check("mid reset tdata", 32'(axis_tdata_out), 32'd0);
    check("mid reset treadys", 32'({arp_axis_tready_o, ip_axis_tready_o}), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    clear_capture();
    push(1'b0, 28);
    wait_frames("post reset", 1, 400);
    check_frame("post reset arp", 0, ARP_DST, 16'h0806, 1'b0, 28, nx);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
